// File: rtl/mem_responder_pkg.sv
// Purpose: shared bus widths, tag layout, block geometry and FSM state type for mem_responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_responder_pkg;

  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_TAG_WIDTH  = 8;
  localparam int TAG_WR_BIT     = BUS_TAG_WIDTH - 1;  // 1 = write, 0 = read
  localparam int BLOCK_BYTES    = 64;
  localparam int WORD_BYTES     = BUS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WAIT,
    RESP
  } state_t;

  function automatic logic tag_is_write(input logic [BUS_TAG_WIDTH-1:0] tag);
    return tag[TAG_WR_BIT];
  endfunction

endpackage

// File: rtl/mem_array.sv
// Purpose: single-port backing store, synchronous write, combinational read, no reset.
// Latency: write lands at the clock edge; read data follows addr in the same cycle.
// Backpressure: none; the owner sequences all accesses.
// Ports: clk; we/addr/wdata write port; rdata = word at addr.
module mem_array #(
  parameter int WORDS = 4096,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Purpose: block-oriented memory target; 64-byte reads and writes as BEATS-beat bursts over a cyc/ack bus.
// Latency: reqack one cycle after a sampled beat; first response beat LATENCY cycles after the last ack.
// Backpressure: response beats hold until bus_respack; requests arriving in WAIT/RESP wait unacknowledged.
// Ports: clk, reset (sync, active-low); request side bus_reqcyc/bus_reqack/bus_req/bus_reqtag;
//        response side bus_respcyc/bus_respack/bus_resp/bus_resptag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 4096,
  parameter int BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int AW   = $clog2(MEM_WORDS);
  localparam int WOFF = $clog2(WORD_BYTES);               // byte-in-word address bits
  localparam int BOFF = $clog2(BLOCK_BYTES) - WOFF;       // word-in-block address bits
  localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [7:0]    LAT_LOAD  = 8'(LATENCY - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [AW-1:0]              base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                       ack_q, ack_d;

  logic [AW-1:0]              req_word;
  logic [AW-1:0]              req_base;
  logic [AW-1:0]              mem_addr;
  logic [BUS_DATA_WIDTH-1:0]  mem_rdata;
  logic                       mem_we;
  logic                       sample;
  logic                       accept;
  logic                       is_wr;

  // Upper address bits are dropped, so accesses wrap modulo the storage size.
  assign req_word = bus_req[AW+WOFF-1:WOFF];
  assign req_base = {req_word[AW-1:BOFF], {BOFF{1'b0}}};
  assign mem_addr = base_q + AW'(beat_q);
  assign is_wr    = tag_is_write(tag_q);

  // A beat is only taken while the previous ack is not showing.
  assign sample = bus_reqcyc && !ack_q;
  // Gated by reset so the edge that aborts a write cannot also store a beat.
  assign mem_we = reset && (state_q == WDATA) && sample;

  mem_array #(
    .WORDS (MEM_WORDS),
    .WIDTH (BUS_DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus_req),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      tag_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      tag_q   <= tag_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    base_d  = base_q;
    tag_d   = tag_q;
    ack_d   = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = sample;
      end

      WDATA: begin
        if (sample) begin
          ack_d = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            cnt_d   = LAT_LOAD;
            state_d = WAIT;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end

      WAIT: begin
        // Loaded with LATENCY-1 in the ack cycle, so RESP starts LATENCY cycles after it.
        if (cnt_q == 8'd0) begin
          beat_d  = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      RESP: begin
        if (bus_respack) begin
          if (is_wr || (beat_q == LAST_BEAT)) begin
            beat_d  = '0;
            state_d = IDLE;
            // Back-to-back: a waiting request is taken on the final-beat edge.
            accept  = sample;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      base_d  = req_base;
      tag_d   = bus_reqtag;
      ack_d   = 1'b1;
      beat_d  = '0;
      cnt_d   = LAT_LOAD;
      state_d = tag_is_write(bus_reqtag) ? WDATA : WAIT;
    end
  end

  assign bus_reqack  = ack_q;
  assign bus_respcyc = (state_q == RESP);
  assign bus_resp    = ((state_q == RESP) && !is_wr) ? mem_rdata : '0;
  assign bus_resptag = (state_q == RESP) ? tag_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int LATENCY   = 4;
  localparam int MEM_WORDS = 4096;
  localparam int BEATS     = 8;
  localparam int AWT       = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_reqcyc = 1'b0;
  logic        bus_reqack;
  logic [63:0] bus_req = '0;
  logic [7:0]  bus_reqtag = '0;
  logic        bus_respcyc;
  logic        bus_respack = 1'b1;
  logic [63:0] bus_resp;
  logic [7:0]  bus_resptag;

  always #5 clk = ~clk;

  mem_responder #(
    .LATENCY   (LATENCY),
    .MEM_WORDS (MEM_WORDS),
    .BEATS     (BEATS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_reqack  (bus_reqack),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [7:0]  tag;
    logic [63:0] addr;
    logic [63:0] seed;
    int          exp_acks;
    int          exp_beats;
  } vec_t;

  exp_t        exp_q[$];
  int          hold_log[$];
  logic [63:0] model [MEM_WORDS];
  vec_t        vecs [9];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // monitor-owned bookkeeping
  int   rx_beat = 0;
  int   n_resp = 0;
  int   rise_cyc = -1;
  int   last_pop_cyc = -1;
  int   cur_hold = 0;
  logic prev_respcyc = 1'b0;

  // stall control, written by the stimulus only
  bit stall_en = 1'b0;
  int stall_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every presented cycle is compared to the queue head,
  // so a held beat must keep its data and tag for as long as it is held.
  always @(negedge clk) begin
    if (bus_respcyc === 1'b1) begin
      if (!prev_respcyc) rise_cyc = cyc;
      n_resp++;
      cur_hold++;
      if (exp_q.size() == 0) begin
        check_int("unexpected_beat", 1, 0);
      end else begin
        check("resp_data", bus_resp, exp_q[0].data);
        check("resp_tag", {56'd0, bus_resptag}, {56'd0, exp_q[0].tag});
        if (bus_respack) begin
          void'(exp_q.pop_front());
          hold_log.push_back(cur_hold);
          cur_hold = 0;
          rx_beat++;
          last_pop_cyc = cyc;
        end
      end
    end
    prev_respcyc = (bus_respcyc === 1'b1);
  end

  // Initiator response-ack: stalls the third beat of a marked transaction for 3 cycles.
  always @(posedge clk) begin
    #1;
    if (stall_en && bus_respcyc && (rx_beat - stall_base == 2) && cur_hold < 3)
      bus_respack = 1'b0;
    else
      bus_respack = 1'b1;
  end

  function automatic int block_base(input logic [63:0] addr);
    logic [63:0] wa;
    wa = addr >> 3;
    return int'(wa[AWT-1:0]) & ~(BEATS - 1);
  endfunction

  task automatic push_expect(input bit wr, input logic [7:0] tag, input logic [63:0] addr,
                             input logic [63:0] seed);
    int b;
    b = block_base(addr);
    if (wr) begin
      for (int i = 0; i < BEATS; i++) model[b + i] = seed + 64'(i);
      exp_q.push_back('{64'd0, tag});
    end else begin
      for (int i = 0; i < BEATS; i++) exp_q.push_back('{model[b + i], tag});
    end
  endtask

  // Present a request and hold it until acked, then drop it.
  task automatic issue_req(input logic [63:0] addr, input logic [7:0] tag, output int ack_cyc);
    int g;
    g = 0;
    ack_cyc = -1;
    @(posedge clk); #1;
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    while (ack_cyc < 0 && g < 50) begin
      @(negedge clk); g++;
      if (bus_reqack) ack_cyc = cyc;
    end
    check_int("req_acked", (ack_cyc >= 0) ? 1 : 0, 1);
    @(posedge clk); #1;
    bus_reqcyc = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk); g++;
    end
    check_int(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_txn(input vec_t v, input bit contiguous);
    int acks, beat, guard, first_ack, last_ack, t_present, rb, nb;
    acks = 0; beat = 0; guard = 0; first_ack = -1; last_ack = -1;
    push_expect(v.wr, v.tag, v.addr, v.seed);
    rb = rx_beat; nb = n_resp;
    @(posedge clk); #1;
    bus_reqcyc = 1'b1; bus_req = v.addr; bus_reqtag = v.tag; t_present = cyc;
    while (guard < 400 && (bus_reqcyc || exp_q.size() != 0)) begin
      @(negedge clk); guard++;
      if (bus_reqack) begin
        acks++;
        last_ack = cyc;
        if (acks == 1) first_ack = cyc;
        if (bus_reqcyc) begin
          @(posedge clk); #1;
          if (v.wr && beat < BEATS) begin
            bus_req = v.seed + 64'(beat);
            beat++;
          end else begin
            bus_reqcyc = 1'b0;
          end
        end
      end
    end
    check_int("txn_drained", exp_q.size() + (bus_reqcyc ? 1 : 0), 0);
    bus_reqcyc = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (bus_reqack) acks++;
    end
    check_int("ack_count", acks, v.exp_acks);
    check_int("ack_delay", first_ack - t_present, 1);
    check_int("first_beat_latency", rise_cyc - last_ack, LATENCY);
    check_int("beat_count", rx_beat - rb, v.exp_beats);
    if (contiguous) check_int("resp_cycles", n_resp - nb, v.exp_beats);
  endtask

  initial begin
    int ack_a, ack_b, g, hb, rb;
    for (int i = 0; i < MEM_WORDS; i++) model[i] = '0;

    vecs[0] = '{1'b1, 8'h81, 64'h1040, 64'hA0, 9, 1};
    vecs[1] = '{1'b0, 8'h05, 64'h1040, 64'h0, 1, 8};
    vecs[2] = '{1'b1, 8'h83, 64'h80, 64'h11, 9, 1};
    vecs[3] = '{1'b0, 8'h06, 64'h80, 64'h0, 1, 8};
    vecs[4] = '{1'b1, 8'h9A, 64'h40, 64'h5500, 9, 1};
    vecs[5] = '{1'b0, 8'h07, 64'h8040, 64'h0, 1, 8};
    vecs[6] = '{1'b0, 8'h08, 64'h1077, 64'h0, 1, 8};
    vecs[7] = '{1'b1, 8'hFF, 64'hFFFF_0000_0000_1040, 64'hC0, 9, 1};
    vecs[8] = '{1'b0, 8'h00, 64'h1040, 64'h0, 1, 8};

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_reqack", {63'd0, bus_reqack}, 64'd0);
    check("rst_respcyc", {63'd0, bus_respcyc}, 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", {56'd0, bus_resptag}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // table-driven transactions; reads check data against the model
    for (int i = 0; i < 9; i++) do_txn(vecs[i], 1'b1);

    // explicit wrap check: 0x40 and MEM_WORDS*8+0x40 map to the same words
    check("wrap_model", model[block_base(64'h8040)], 64'h5500);

    // respack low for 3 cycles on beat 2
    hb = hold_log.size();
    stall_base = rx_beat;
    stall_en = 1'b1;
    do_txn('{1'b0, 8'h21, 64'h40, 64'h0, 1, 8}, 1'b0);
    stall_en = 1'b0;
    check_int("hold_beat2", hold_log[hb + 2], 4);
    check_int("hold_beat3", hold_log[hb + 3], 1);

    // second request raised during RESP
    push_expect(1'b0, 8'h31, 64'h1040, 64'h0);
    issue_req(64'h1040, 8'h31, ack_a);
    g = 0;
    while (!bus_respcyc && g < 50) begin
      @(posedge clk); #1; g++;
    end
    push_expect(1'b0, 8'h32, 64'h80, 64'h0);
    bus_reqcyc = 1'b1; bus_req = 64'h80; bus_reqtag = 8'h32;
    ack_b = -1; g = 0;
    while (ack_b < 0 && g < 100) begin
      @(negedge clk); g++;
      if (bus_respcyc) check("no_ack_in_resp", {63'd0, bus_reqack}, 64'd0);
      if (bus_reqack) ack_b = cyc;
    end
    check_int("second_ack_after_last_beat", ack_b - last_pop_cyc, 1);
    @(posedge clk); #1;
    bus_reqcyc = 1'b0;
    wait_drain("second_req_drained");

    // reset during beat 3 of a read
    push_expect(1'b0, 8'h0A, 64'h80, 64'h0);
    rb = rx_beat;
    issue_req(64'h80, 8'h0A, ack_a);
    g = 0;
    while (!(bus_respcyc && (rx_beat - rb == 3)) && g < 100) begin
      @(posedge clk); #1; g++;
    end
    check_int("abort_at_beat3", rx_beat - rb, 3);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_respcyc", {63'd0, bus_respcyc}, 64'd0);
    check("abort_resp", bus_resp, 64'd0);
    check("abort_resptag", {56'd0, bus_resptag}, 64'd0);
    check("abort_reqack", {63'd0, bus_reqack}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_beat", {63'd0, bus_respcyc}, 64'd0);
    end
    do_txn('{1'b0, 8'h0B, 64'h80, 64'h0, 1, 8}, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, 4: cycles from the request-ack cycle to the first response beat (range 1..255).
REQ-002 Parameter MEM_WORDS, 4096: 64-bit words of backing storage (power of 2).
REQ-003 Parameter BEATS, 8: bus beats per 64-byte block.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 bus_reqcyc  input  1  initiator request or write-data beat valid.
REQ-007 bus_reqack  output  1  one-cycle acceptance pulse.
REQ-008 bus_req  input  BUS_DATA_WIDTH  address on a request beat; data on a write-data beat.
REQ-009 bus_reqtag  input  BUS_TAG_WIDTH  MSB = write (1) / read (0); remaining bits form the transaction ID.
REQ-010 bus_respcyc  output  1  response beat valid.
REQ-011 bus_respack  input  1  initiator accepts the current response beat.
REQ-012 bus_resp  output  BUS_DATA_WIDTH  response data.
REQ-013 bus_resptag  output  BUS_TAG_WIDTH  echo of the request tag.

Function
REQ-014 FSM states SHALL be IDLE, WDATA, WAIT and RESP.
REQ-015 IDLE: bus_reqcyc sampled high at edge T -> latch the block base (bus_req with bits [5:0] cleared) and the tag, then pulse bus_reqack during cycle T+1.
- Read requests go to WAIT.
- Write requests go to WDATA.
REQ-016 A request or data beat SHALL be sampled only when bus_reqack is low, so each beat takes at least 2 cycles.
REQ-017 WDATA: each sampled beat writes bus_req to word (base/8 + beat) and pulses bus_reqack; after BEATS beats, go to WAIT.
REQ-018 WAIT: count LATENCY cycles from the ack cycle; the first bus_respcyc SHALL be high in cycle T+1+LATENCY of the last accepted beat.
REQ-019 RESP, read: drive beat k (0..BEATS-1) = word (base/8 + k), with bus_respcyc=1 and bus_resptag = latched tag.
REQ-020 RESP, write: drive a single completion beat with bus_resp=0 and bus_resptag = latched tag.
REQ-021 bus_resp and bus_resptag SHALL be held stable while bus_respcyc=1 and bus_respack=0; a beat advances only at an edge where both are high.
REQ-022 After the final beat is acknowledged, return to IDLE with bus_respcyc=0 in the next cycle; a new request may be sampled at that same edge.
REQ-023 Word index = address bits [log2(MEM_WORDS)+2:3]; higher address bits are ignored, so accesses wrap modulo the memory size.
REQ-024 bus_reqcyc high in WAIT or RESP SHALL NOT be acknowledged; the initiator holds it until IDLE.
REQ-025 bus_respack high while bus_respcyc=0 SHALL be ignored.
REQ-026 A read of a block that was just written SHALL return the new data, since the write completes before its completion beat.

Reset
REQ-027 reset low at an edge -> state IDLE, counters 0, bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0 from the next cycle.
REQ-028 Reset mid-transaction SHALL abort it without a response beat.
REQ-029 Reset SHALL NOT clear storage contents; a write aborted by reset leaves words already written updated.

Structure
REQ-030 Shared package SHALL hold BUS_DATA_WIDTH (64), BUS_TAG_WIDTH, the write-bit position, BLOCK_BYTES (64) and the FSM state enum.
REQ-031 Storage SHALL be a separate sub-module mem_array: single port, synchronous write, combinational read, MEM_WORDS x 64, no reset.

Verification
REQ-032 Read, tag 0x05, address 0x1040, preloaded words 0x208..0x20F = 0xA0..0xA7, respack always high.
- bus_reqack in cycle T+1; beats 0xA0..0xA7 in cycles T+5..T+12; bus_resptag=0x05.
REQ-033 Read with respack low for 3 cycles on beat 2.
- Beat 2 data and tag held for 4 cycles; remaining beats follow in order.
REQ-034 Write, tag MSB set, address 0x80, data 0x11..0x18.
- 9 ack pulses, one completion beat with bus_resp=0.
- A following read of 0x80 returns 0x11..0x18.
REQ-035 Second bus_reqcyc asserted during RESP.
- No bus_reqack until IDLE; it is then accepted and serviced correctly.
REQ-036 Reset low at beat 3 of a read.
- bus_respcyc=0 the next cycle; a new read of the same block returns the full original data.
REQ-037 Read of address MEM_WORDS*8 + 0x40 returns the same data as a read of 0x40.
